// File: rtl/rvx_spi_target_pkg.sv
// Shared definitions for the RVX SPI target: FSM state encoding, synchronizer depth
// and byte width.
package rvx_spi_target_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int BYTE_BITS   = 8;
  localparam int CNT_BITS    = $clog2(BYTE_BITS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/rvx_spi_target_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with a delay register that
// produces one-cycle rise/fall pulses aligned to the synchronized level.
module rvx_sync_edge
  import rvx_spi_target_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/rvx_spi_target.sv
// SPI target: oversamples sclk/mosi/cs, deserializes bytes to an rx stream and
// serializes a tx stream onto miso. RVX_SPI_TARGET_STATUS_EN adds over/underrun counters.
module rvx_spi_target
  import rvx_spi_target_pkg::*;
#(
  parameter logic [1:0] SPI_MODE = 2'd0,
  parameter logic [7:0] TX_FILL  = 8'hFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [BYTE_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic [BYTE_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
`ifdef RVX_SPI_TARGET_STATUS_EN
  input  logic                 status_clear,
  output logic [7:0]           overrun_count,
  output logic [7:0]           underrun_count,
`endif
  output state_t               dbg_state
);

  localparam logic CPOL = SPI_MODE[1];
  localparam logic CPHA = SPI_MODE[0];

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
  logic cs_rise, cs_fall, cs_level_unused;

  // cs resets to "low" so a cs held low through reset never looks like a fresh fall.
  rvx_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
    .clock(clock), .reset(reset), .d(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  rvx_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d(mosi),
    .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  rvx_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
    .clock(clock), .reset(reset), .d(cs),
    .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  state_t                state_q;
  logic [CNT_BITS-1:0]   bit_cnt_q;
  logic [BYTE_BITS-1:0]  shift_in_q;
  logic [BYTE_BITS-1:0]  shift_out_q;
  logic [BYTE_BITS-1:0]  rx_data_q;
  logic                  rx_valid_q;
  logic                  tx_ready_q;
  logic                  busy_q;
  logic                  miso_oe_q;

  logic lead_edge, trail_edge, sample_edge, drive_edge;
  logic active_edge_ok, byte_done, load_now;

  always_comb begin
    lead_edge      = CPOL ? sclk_fall : sclk_rise;
    trail_edge     = CPOL ? sclk_rise : sclk_fall;
    sample_edge    = CPHA ? trail_edge : lead_edge;
    drive_edge     = CPHA ? lead_edge : trail_edge;
    // A cs rise in the same cycle as an sclk edge wins; the edge is dropped.
    active_edge_ok = (state_q == ST_ACTIVE) && !cs_rise;
    byte_done      = active_edge_ok && sample_edge && (bit_cnt_q == CNT_BITS'(BYTE_BITS - 1));
    load_now       = ((state_q == ST_IDLE) && cs_fall && !CPHA) ||
                     (active_edge_ok && drive_edge && (bit_cnt_q == '0));
  end

  // rx stream: a byte transfers when rx_valid && rx_ready; new data always overwrites.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= TX_FILL;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      tx_ready_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (byte_done) begin
        rx_data_q  <= {shift_in_q[BYTE_BITS-2:0], mosi_sync};
        rx_valid_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ACTIVE;
            busy_q    <= 1'b1;
            miso_oe_q <= 1'b1;
            bit_cnt_q <= '0;
            if (CPHA) shift_out_q <= TX_FILL;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            bit_cnt_q <= '0;
          end else if (sample_edge) begin
            shift_in_q <= {shift_in_q[BYTE_BITS-2:0], mosi_sync};
            bit_cnt_q  <= bit_cnt_q + 1'b1;
          end else if (drive_edge && (bit_cnt_q != '0)) begin
            shift_out_q <= {shift_out_q[BYTE_BITS-2:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Loads override the CPHA=1 fill preset and the shift above.
      if (load_now) begin
        shift_out_q <= tx_valid ? tx_data : TX_FILL;
        tx_ready_q  <= 1'b1;
      end
    end
  end

`ifdef RVX_SPI_TARGET_STATUS_EN
  logic [7:0] overrun_q, underrun_q;

  always_ff @(posedge clock) begin
    if (reset || status_clear) begin
      overrun_q  <= '0;
      underrun_q <= '0;
    end else begin
      if (byte_done && rx_valid_q && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
      if (load_now && !tx_valid && (underrun_q != 8'hFF)) underrun_q <= underrun_q + 8'd1;
    end
  end

  assign overrun_count  = overrun_q;
  assign underrun_count = underrun_q;
`endif

  assign miso      = miso_oe_q & shift_out_q[BYTE_BITS-1];
  assign miso_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = tx_ready_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rvx_spi_target.sv
// Bench for rvx_spi_target: three targets (modes 0, 1, 3) driven by a behavioural
// SPI initiator; table-driven single-byte vectors plus multi-byte/abort/reset sequences.
module tb_rvx_spi_target;
  import rvx_spi_target_pkg::*;

  localparam int HALF = 8;

  logic       clock, reset, mosi, rx_ready, tx_valid, status_clear;
  logic [7:0] tx_data;
  logic [2:0] cs, sclk;

  logic       miso_w [3];
  logic       oe_w [3];
  logic [7:0] rxd_w [3];
  logic       rxv_w [3];
  logic       txr_w [3];
  logic       busy_w [3];
  state_t     st_w [3];
  logic [7:0] ovr_w [3];
  logic [7:0] und_w [3];

  int n_cmp = 0;
  int n_fail = 0;
  int txr_cnt [3] = '{0, 0, 0};

  rvx_spi_target #(.SPI_MODE(2'd0)) u_mode0 (
    .clock(clock), .reset(reset), .sclk(sclk[0]), .mosi(mosi), .cs(cs[0]),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .rx_data(rxd_w[0]), .rx_valid(rxv_w[0]),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[0]),
    .busy(busy_w[0]),
`ifdef RVX_SPI_TARGET_STATUS_EN
    .status_clear(status_clear), .overrun_count(ovr_w[0]), .underrun_count(und_w[0]),
`endif
    .dbg_state(st_w[0])
  );

  rvx_spi_target #(.SPI_MODE(2'd1)) u_mode1 (
    .clock(clock), .reset(reset), .sclk(sclk[1]), .mosi(mosi), .cs(cs[1]),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .rx_data(rxd_w[1]), .rx_valid(rxv_w[1]),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[1]),
    .busy(busy_w[1]),
`ifdef RVX_SPI_TARGET_STATUS_EN
    .status_clear(status_clear), .overrun_count(ovr_w[1]), .underrun_count(und_w[1]),
`endif
    .dbg_state(st_w[1])
  );

  rvx_spi_target #(.SPI_MODE(2'd3)) u_mode3 (
    .clock(clock), .reset(reset), .sclk(sclk[2]), .mosi(mosi), .cs(cs[2]),
    .miso(miso_w[2]), .miso_oe(oe_w[2]), .rx_data(rxd_w[2]), .rx_valid(rxv_w[2]),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[2]),
    .busy(busy_w[2]),
`ifdef RVX_SPI_TARGET_STATUS_EN
    .status_clear(status_clear), .overrun_count(ovr_w[2]), .underrun_count(und_w[2]),
`endif
    .dbg_state(st_w[2])
  );

`ifndef RVX_SPI_TARGET_STATUS_EN
  initial for (int k = 0; k < 3; k++) begin
    ovr_w[k] = '0;
    und_w[k] = '0;
  end
`endif

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock)
    for (int k = 0; k < 3; k++)
      if (txr_w[k]) txr_cnt[k] <= txr_cnt[k] + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Driver: index 0 = mode 0, 1 = mode 1, 2 = mode 3
  task automatic spi_bits(input int idx, input logic [7:0] out_byte, input int nbits,
                          output logic [7:0] in_byte);
    logic cpol, cpha;
    cpol = (idx == 2);
    cpha = (idx != 0);
    in_byte = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi = out_byte[7-b];
        clocks(HALF);
        in_byte = {in_byte[6:0], miso_w[idx]};
        sclk[idx] = ~cpol;
        clocks(HALF);
        sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = out_byte[7-b];
        clocks(HALF);
        in_byte = {in_byte[6:0], miso_w[idx]};
        sclk[idx] = cpol;
        clocks(HALF);
      end
    end
    if (!cpha) clocks(HALF);
  endtask

  task automatic cs_set(input int idx, input logic v);
    cs[idx] = v;
    clocks(HALF);
  endtask

  task automatic rx_consume();
    rx_ready = 1'b1;
    clocks(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_status();
    status_clear = 1'b1;
    clocks(1);
    status_clear = 1'b0;
  endtask

  typedef struct {
    int         idx;
    logic       tv;
    logic [7:0] td;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
    int         exp_txr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] got, got2;
    int base;

    vecs[0] = '{idx: 0, tv: 1'b1, td: 8'h3C, mo: 8'hA5, exp_rx: 8'hA5, exp_miso: 8'h3C, exp_txr: 2};
    vecs[1] = '{idx: 1, tv: 1'b0, td: 8'h55, mo: 8'h0F, exp_rx: 8'h0F, exp_miso: 8'hFF, exp_txr: 1};
    vecs[2] = '{idx: 2, tv: 1'b1, td: 8'h96, mo: 8'h69, exp_rx: 8'h69, exp_miso: 8'h96, exp_txr: 1};
    vecs[3] = '{idx: 1, tv: 1'b1, td: 8'h81, mo: 8'hC3, exp_rx: 8'hC3, exp_miso: 8'h81, exp_txr: 1};
    vecs[4] = '{idx: 0, tv: 1'b0, td: 8'h77, mo: 8'h00, exp_rx: 8'h00, exp_miso: 8'hFF, exp_txr: 2};

    reset = 1'b1; mosi = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0;
    status_clear = 1'b0; cs = 3'b111; sclk = 3'b100;
    clocks(5);
    check("reset_miso", miso_w[0], 1'b0);
    check("reset_miso_oe", oe_w[0], 1'b0);
    check("reset_rx_data", rxd_w[0], 8'h00);
    check("reset_rx_valid", rxv_w[0], 1'b0);
    check("reset_tx_ready", txr_w[0], 1'b0);
    check("reset_busy", busy_w[0], 1'b0);
    check("reset_state", st_w[2], ST_IDLE);
    reset = 1'b0;
    clocks(10);

    foreach (vecs[i]) begin
      clear_status();
      tx_valid = vecs[i].tv;
      tx_data  = vecs[i].td;
      base = txr_cnt[vecs[i].idx];
      cs_set(vecs[i].idx, 1'b0);
      check($sformatf("v%0d_busy", i), busy_w[vecs[i].idx], 1'b1);
      check($sformatf("v%0d_miso_oe", i), oe_w[vecs[i].idx], 1'b1);
      spi_bits(vecs[i].idx, vecs[i].mo, 8, got);
      check($sformatf("v%0d_rx_data", i), rxd_w[vecs[i].idx], vecs[i].exp_rx);
      check($sformatf("v%0d_rx_valid", i), rxv_w[vecs[i].idx], 1'b1);
      check($sformatf("v%0d_miso_byte", i), got, vecs[i].exp_miso);
      cs_set(vecs[i].idx, 1'b1);
      check($sformatf("v%0d_idle_oe", i), oe_w[vecs[i].idx], 1'b0);
      check($sformatf("v%0d_tx_ready_pulses", i), txr_cnt[vecs[i].idx] - base, vecs[i].exp_txr);
`ifdef RVX_SPI_TARGET_STATUS_EN
      check($sformatf("v%0d_underrun_count", i), und_w[vecs[i].idx],
            vecs[i].tv ? 0 : vecs[i].exp_txr);
`endif
      rx_consume();
      check($sformatf("v%0d_rx_valid_cleared", i), rxv_w[vecs[i].idx], 1'b0);
    end

    // Mode 3: two back-to-back bytes under one cs
    tx_valid = 1'b1;
    tx_data  = 8'hC0;
    base = txr_cnt[2];
    cs_set(2, 1'b0);
    spi_bits(2, 8'h12, 8, got);
    check("m3_rx_first", rxd_w[2], 8'h12);
    check("m3_rx_valid_first", rxv_w[2], 1'b1);
    rx_consume();
    tx_data = 8'h0F;
    spi_bits(2, 8'h34, 8, got2);
    check("m3_rx_second", rxd_w[2], 8'h34);
    check("m3_rx_valid_second", rxv_w[2], 1'b1);
    check("m3_miso_first", got, 8'hC0);
    check("m3_miso_second", got2, 8'h0F);
    cs_set(2, 1'b1);
    check("m3_tx_ready_pulses", txr_cnt[2] - base, 2);
    rx_consume();

    // Overrun: three bytes with no consumer
    clear_status();
    tx_data = 8'h00;
    cs_set(0, 1'b0);
    spi_bits(0, 8'h01, 8, got);
    spi_bits(0, 8'h02, 8, got);
    spi_bits(0, 8'h03, 8, got);
    cs_set(0, 1'b1);
    check("ovr_rx_data", rxd_w[0], 8'h03);
    check("ovr_rx_valid", rxv_w[0], 1'b1);
`ifdef RVX_SPI_TARGET_STATUS_EN
    check("ovr_overrun_count", ovr_w[0], 8'd2);
    clear_status();
    check("ovr_overrun_cleared", ovr_w[0], 8'd0);
`endif
    rx_consume();

    // Partial byte discarded on cs rise, then a full byte
    cs_set(0, 1'b0);
    spi_bits(0, 8'hA5, 5, got);
    cs_set(0, 1'b1);
    check("partial_rx_valid", rxv_w[0], 1'b0);
    check("partial_rx_data_kept", rxd_w[0], 8'h03);
    cs_set(0, 1'b0);
    spi_bits(0, 8'h5A, 8, got);
    cs_set(0, 1'b1);
    check("after_partial_rx_data", rxd_w[0], 8'h5A);
    check("after_partial_rx_valid", rxv_w[0], 1'b1);

    // Reset mid-transfer with cs held low
    cs_set(0, 1'b0);
    spi_bits(0, 8'hFF, 4, got);
    reset = 1'b1;
    clocks(2);
    check("midrst_miso", miso_w[0], 1'b0);
    check("midrst_miso_oe", oe_w[0], 1'b0);
    check("midrst_rx_data", rxd_w[0], 8'h00);
    check("midrst_rx_valid", rxv_w[0], 1'b0);
    check("midrst_tx_ready", txr_w[0], 1'b0);
    check("midrst_busy", busy_w[0], 1'b0);
    reset = 1'b0;
    clocks(4);
    spi_bits(0, 8'h5A, 8, got);
    check("midrst_no_byte", rxv_w[0], 1'b0);
    check("midrst_still_idle", st_w[0], ST_IDLE);
    cs_set(0, 1'b1);
    cs_set(0, 1'b0);
    spi_bits(0, 8'hC3, 8, got);
    cs_set(0, 1'b1);
    check("postrst_rx_data", rxd_w[0], 8'hC3);
    check("postrst_rx_valid", rxv_w[0], 1'b1);
    rx_consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
